// File: rtl/contador_vl_detector.sv
// contador_vl_detector: locks onto a 0..15..0 triangle sample stream and reports peaks, troughs and mismatches
module contador_vl_detector #(
    parameter int LOCK_N = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] data_in,
    output logic       locked,
    output logic       dir,
    output logic [3:0] expected,
    output logic       peak,
    output logic       trough,
    output logic       error,
    output logic [7:0] cycle_count,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {HUNT, SYNC, TRACK, LOCK} state_t;
    state_t state, state_n;
    logic [3:0] prev, prev_n, match_cnt, match_n, match_inc, exp_n, upd_exp;
    logic dir_n, peak_n, trough_n, error_n, step_up, step_dn, hit, base_dir, upd_dir;
    logic [7:0] cyc_n, err_n;
    // next-sample prediction and next-state/output selection
    always_comb begin
        step_up   = prev != 4'd15 && data_in == prev + 4'd1;
        step_dn   = prev != 4'd0 && data_in == prev - 4'd1;
        hit       = data_in == expected;
        match_inc = match_cnt + 4'd1;
        base_dir  = state == SYNC ? step_up : dir;
        upd_dir   = data_in == 4'd15 ? 1'b0 : data_in == 4'd0 ? 1'b1 : base_dir;
        upd_exp   = data_in == 4'd15 ? 4'd14 : data_in == 4'd0 ? 4'd1 :
                    base_dir ? data_in + 4'd1 : data_in - 4'd1;
        state_n   = state;
        prev_n    = prev;
        match_n   = match_cnt;
        dir_n     = dir;
        exp_n     = expected;
        peak_n    = 1'b0;
        trough_n  = 1'b0;
        error_n   = 1'b0;
        cyc_n     = cycle_count;
        err_n     = err_count;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    prev_n  = data_in;
                    state_n = SYNC;
                end
                SYNC: begin
                    if (step_up || step_dn) begin
                        match_n = 4'd1;
                        dir_n   = upd_dir;
                        exp_n   = upd_exp;
                        state_n = TRACK;
                    end else begin
                        prev_n = data_in;
                    end
                end
                TRACK: begin
                    if (hit) begin
                        match_n = match_inc;
                        dir_n   = upd_dir;
                        exp_n   = upd_exp;
                        state_n = match_inc == 4'(LOCK_N) ? LOCK : TRACK;
                    end else begin
                        prev_n  = data_in;
                        match_n = 4'd0;
                        state_n = SYNC;
                    end
                end
                default: begin
                    if (hit) begin
                        dir_n    = upd_dir;
                        exp_n    = upd_exp;
                        peak_n   = data_in == 4'd15;
                        trough_n = data_in == 4'd0;
                        cyc_n    = cycle_count + {7'd0, data_in == 4'd0};
                    end else begin
                        error_n = 1'b1;
                        err_n   = err_count == 8'd255 ? err_count : err_count + 8'd1;
                        prev_n  = data_in;
                        match_n = 4'd0;
                        state_n = SYNC;
                    end
                end
            endcase
        end
    end
    // state and registered outputs, reset wins over everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= HUNT;
            prev        <= 4'd0;
            match_cnt   <= 4'd0;
            dir         <= 1'b1;
            expected    <= 4'd0;
            locked      <= 1'b0;
            peak        <= 1'b0;
            trough      <= 1'b0;
            error       <= 1'b0;
            cycle_count <= 8'd0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_n;
            prev        <= prev_n;
            match_cnt   <= match_n;
            dir         <= dir_n;
            expected    <= exp_n;
            locked      <= state_n == LOCK;
            peak        <= peak_n;
            trough      <= trough_n;
            error       <= error_n;
            cycle_count <= cyc_n;
            err_count   <= err_n;
        end
    end
endmodule

// File: tb/tb_contador_vl_detector.sv
// tb_contador_vl_detector: directed and random checks against a run-length model of the triangle tracker
module tb_contador_vl_detector;
    localparam int LOCK_N = 4;
    logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic locked, dir, peak, trough, error;
    logic [3:0] expected;
    logic [7:0] cycle_count, err_count;
    int checks = 0, failures = 0;
    int m_last, m_run, m_cyc, m_err, m_exp;
    logic m_dir, m_pk, m_tr, m_er;

    contador_vl_detector #(.LOCK_N(LOCK_N)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .locked(locked), .dir(dir), .expected(expected), .peak(peak), .trough(trough),
        .error(error), .cycle_count(cycle_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic check_all();
        chk("locked", {31'd0, locked}, (m_run >= LOCK_N) ? 32'd1 : 32'd0);
        chk("dir", {31'd0, dir}, {31'd0, m_dir});
        chk("expected", {28'd0, expected}, 32'(m_exp));
        chk("peak", {31'd0, peak}, {31'd0, m_pk});
        chk("trough", {31'd0, trough}, {31'd0, m_tr});
        chk("error", {31'd0, error}, {31'd0, m_er});
        chk("cycle_count", {24'd0, cycle_count}, 32'(m_cyc));
        chk("err_count", {24'd0, err_count}, 32'(m_err));
    endtask

    // next expectation follows the triangle: bounce at the ends, otherwise keep the last step's sign
    task automatic next_exp(input int s);
        m_exp = s == 15 ? 14 : s == 0 ? 1 : 2 * s - m_last;
        m_dir = m_exp > s;
    endtask

    task automatic model_step(input int s);
        m_pk = 0; m_tr = 0; m_er = 0;
        if (m_last < 0) m_last = s;
        else if (m_run == 0) begin
            if (s == m_last + 1 || s == m_last - 1) begin
                m_run = 1;
                next_exp(s);
            end
            m_last = s;
        end else if (s == m_exp) begin
            if (m_run >= LOCK_N) begin
                m_pk = s == 15;
                m_tr = s == 0;
                if (m_tr) m_cyc = (m_cyc + 1) % 256;
            end else m_run++;
            next_exp(s);
            m_last = s;
        end else begin
            if (m_run >= LOCK_N) begin
                m_er = 1;
                if (m_err < 255) m_err++;
            end
            m_run = 0;
            m_last = s;
        end
    endtask

    task automatic cycle(input logic v, input int s);
        @(negedge clock);
        reset = 1'b0; in_valid = v; data_in = 4'(s);
        @(posedge clock);
        #1;
        if (v) model_step(s);
        else begin m_pk = 0; m_tr = 0; m_er = 0; end
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b1; data_in = 4'($urandom_range(0, 15));
        @(posedge clock);
        #1;
        m_last = -1; m_run = 0; m_cyc = 0; m_err = 0; m_exp = 0; m_dir = 1;
        m_pk = 0; m_tr = 0; m_er = 0;
        check_all();
    endtask

    task automatic feed(input int a, input int b);
        if (a <= b) for (int i = a; i <= b; i++) cycle(1'b1, i);
        else for (int i = a; i >= b; i--) cycle(1'b1, i);
    endtask

    function automatic int legal_next();
        if (m_last < 0) return $urandom_range(0, 15);
        if (m_run == 0) return m_last == 15 ? 14 : m_last + 1;
        return m_exp;
    endfunction

    initial begin
        do_reset();
        do_reset();
        chk("rst_dir", {31'd0, dir}, 32'd1);
        chk("rst_exp", {28'd0, expected}, 32'd0);
        feed(0, 4);
        chk("lock_after_4", {31'd0, locked}, 32'd1);
        chk("lock_exp5", {28'd0, expected}, 32'd5);
        feed(5, 15);
        chk("peak15", {31'd0, peak}, 32'd1);
        chk("peak_exp14", {28'd0, expected}, 32'd14);
        feed(14, 0);
        chk("trough0", {31'd0, trough}, 32'd1);
        chk("cyc1", {24'd0, cycle_count}, 32'd1);
        chk("trough_exp1", {28'd0, expected}, 32'd1);
        feed(1, 6);
        cycle(1'b1, 9);
        chk("err_pulse", {31'd0, error}, 32'd1);
        chk("err_cnt1", {24'd0, err_count}, 32'd1);
        chk("err_unlock", {31'd0, locked}, 32'd0);
        feed(10, 13);
        chk("relock13", {31'd0, locked}, 32'd1);
        feed(14, 15);
        feed(14, 1);
        chk("down_exp0", {28'd0, expected}, 32'd0);
        cycle(1'b1, 15);
        chk("wrap_err", {31'd0, error}, 32'd1);
        chk("wrap_no_trough", {31'd0, trough}, 32'd0);
        chk("wrap_cyc", {24'd0, cycle_count}, 32'd1);
        feed(14, 10);
        for (int i = 0; i < 5; i++) cycle(1'b0, $urandom_range(0, 15));
        chk("idle_locked", {31'd0, locked}, 32'd1);
        cycle(1'b1, 9);
        chk("resume_locked", {31'd0, locked}, 32'd1);
        for (int i = 0; i < 400; i++) begin
            logic v;
            int s;
            v = $urandom_range(0, 3) != 0;
            s = $urandom_range(0, 7) == 0 ? $urandom_range(0, 15) : legal_next();
            cycle(v, s);
        end
        do_reset();
        for (int n = 0; n < 400 && m_cyc != 5; n++) cycle(1'b1, legal_next());
        chk("cyc5", {24'd0, cycle_count}, 32'd5);
        for (int i = 0; i < 7; i++) cycle(1'b1, legal_next());
        do_reset();
        chk("midreset_cyc", {24'd0, cycle_count}, 32'd0);
        chk("midreset_locked", {31'd0, locked}, 32'd0);
        for (int i = 0; i < LOCK_N; i++) begin
            cycle(1'b1, 3 + i);
            chk("no_early_lock", {31'd0, locked}, 32'd0);
        end
        cycle(1'b1, 3 + LOCK_N);
        chk("fresh_lock", {31'd0, locked}, 32'd1);
        for (int k = 0; k < 260; k++) begin
            feed(0, 4);
            cycle(1'b1, 9);
        end
        chk("err_sat", {24'd0, err_count}, 32'd255);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
